// File: rtl/reorder_buffer_pkg.sv
// Shared constants and types for the reorder buffer.
// Holds the tag/register/data widths, the reserved "no tag" and "no register"
// values, the RISC-V opcodes the ROB must recognise at commit, the per-entry
// record, and a helper that classifies an opcode for commit handling.
package reorder_buffer_pkg;

  localparam int unsigned ROB_WIDTH  = 4;
  localparam int unsigned ROB_SIZE   = 16;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned REG_WIDTH  = 5;

  localparam logic [ROB_WIDTH-1:0] ZERO_ROB = '0;
  localparam logic [REG_WIDTH-1:0] ZERO_REG = '0;

  localparam logic [6:0] BRANCH_OP = 7'b1100011;
  localparam logic [6:0] STORE_OP  = 7'b0100011;
  localparam logic [6:0] JALR_OP   = 7'b1100111;
  localparam logic [6:0] JAL_OP    = 7'b1101111;

  typedef enum logic [2:0] {
    OPC_OTHER,
    OPC_BRANCH,
    OPC_STORE,
    OPC_JAL,
    OPC_JALR
  } op_class_e;

  typedef struct packed {
    logic                  valid;
    logic                  ready;
    logic [REG_WIDTH-1:0]  rd;
    logic [DATA_WIDTH-1:0] pc;
    logic [6:0]            opcode;
    logic                  predicted_taken;
    logic [DATA_WIDTH-1:0] value;
    logic                  taken;
    logic [DATA_WIDTH-1:0] target;
  } rob_entry_t;

  function automatic op_class_e classify_op(input logic [6:0] opcode);
    case (opcode)
      BRANCH_OP: return OPC_BRANCH;
      STORE_OP:  return OPC_STORE;
      JAL_OP:    return OPC_JAL;
      JALR_OP:   return OPC_JALR;
      default:   return OPC_OTHER;
    endcase
  endfunction

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer.
// Decode assigns at most one instruction per cycle into the slot named by
// out_rob_tobe_tag; results arrive over the CDB; the oldest ready entry
// commits in program order, producing registered regfile / store pulses and,
// for a mispredicted branch or any JALR, a rollback pulse with restart PC.
// Tag 0 is reserved as "no tag"; usable slots are 1..ROB_SIZE-1.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   in_assign_ena .. in_predicted_taken   allocation request from decode
//   out_rob_tobe_tag, out_full       next tag to be assigned / no free slot
//   in_query_tag1/2                  operand tags from decode
//   out_query_tag1/2_ready, out_query_ready_value1/2   operand readiness/value
//   in_cdb_*                         result broadcast (value, outcome, target)
//   out_commit_*                     registered regfile commit + committing tag
//   out_store_commit_ena             registered store-release pulse
//   out_rollback, out_rollback_pc    registered flush pulse + restart PC
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned ROB_SIZE = reorder_buffer_pkg::ROB_SIZE,
  parameter int unsigned TAG_W    = reorder_buffer_pkg::ROB_WIDTH
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             in_assign_ena,
  input  logic [4:0]       in_reg_rd,
  input  logic [31:0]      in_current_pc,
  input  logic [31:0]      in_inst,
  input  logic             in_predicted_taken,
  output logic [TAG_W-1:0] out_rob_tobe_tag,
  output logic             out_full,

  input  logic [TAG_W-1:0] in_query_tag1,
  input  logic [TAG_W-1:0] in_query_tag2,
  output logic             out_query_tag1_ready,
  output logic             out_query_tag2_ready,
  output logic [31:0]      out_query_ready_value1,
  output logic [31:0]      out_query_ready_value2,

  input  logic             in_cdb_ena,
  input  logic [TAG_W-1:0] in_cdb_tag,
  input  logic [31:0]      in_cdb_value,
  input  logic             in_cdb_taken,
  input  logic [31:0]      in_cdb_target,

  output logic             out_commit_ena,
  output logic [4:0]       out_commit_reg,
  output logic [31:0]      out_commit_value,
  output logic [TAG_W-1:0] out_commit_tag,
  output logic             out_store_commit_ena,
  output logic             out_rollback,
  output logic [31:0]      out_rollback_pc
);

  rob_entry_t       entries [ROB_SIZE];
  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [TAG_W-1:0] count;

  logic [TAG_W-1:0] head_n;
  logic [TAG_W-1:0] tail_n;
  logic [TAG_W-1:0] count_n;

  rob_entry_t       head_entry;
  op_class_e        head_class;
  logic             commit_go;
  logic             commit_writes_reg;
  logic             mispredict;
  logic [31:0]      redirect_pc;
  logic             alloc_go;
  logic             cdb_write;
  rob_entry_t       alloc_entry;

  // Only the opcode field of the instruction is needed here.
  logic             inst_upper_unused;
  assign inst_upper_unused = ^in_inst[31:7];

  function automatic logic [TAG_W-1:0] ptr_next(input logic [TAG_W-1:0] p);
    if (p == TAG_W'(ROB_SIZE - 1)) begin
      return TAG_W'(1);
    end
    return p + TAG_W'(1);
  endfunction

  // Commit decision and mispredict detection for the oldest entry.
  always_comb begin
    head_entry        = entries[head];
    head_class        = classify_op(head_entry.opcode);
    commit_go         = head_entry.valid && head_entry.ready;
    commit_writes_reg = (head_entry.rd != ZERO_REG) &&
                        (head_class != OPC_BRANCH) &&
                        (head_class != OPC_STORE);
    mispredict        = 1'b0;
    redirect_pc       = '0;
    if (commit_go) begin
      case (head_class)
        OPC_BRANCH: begin
          if (head_entry.taken != head_entry.predicted_taken) begin
            mispredict  = 1'b1;
            redirect_pc = head_entry.taken ? head_entry.target
                                           : head_entry.pc + 32'd4;
          end
        end
        OPC_JALR: begin
          mispredict  = 1'b1;
          redirect_pc = head_entry.target;
        end
        default: ;
      endcase
    end
  end

  // Next-state for pointers and occupancy; a flush overrides everything.
  always_comb begin
    alloc_go  = in_assign_ena && !out_full && !mispredict;
    cdb_write = in_cdb_ena && (in_cdb_tag != '0) && entries[in_cdb_tag].valid;
    head_n    = head;
    tail_n    = tail;
    count_n   = count;
    if (mispredict) begin
      head_n  = TAG_W'(1);
      tail_n  = TAG_W'(1);
      count_n = '0;
    end else begin
      if (alloc_go) begin
        tail_n = ptr_next(tail);
      end
      if (commit_go) begin
        head_n = ptr_next(head);
      end
      case ({alloc_go, commit_go})
        2'b10:   count_n = count + TAG_W'(1);
        2'b01:   count_n = count - TAG_W'(1);
        default: count_n = count;
      endcase
    end

    alloc_entry                 = '0;
    alloc_entry.valid           = 1'b1;
    alloc_entry.rd              = in_reg_rd;
    alloc_entry.pc              = in_current_pc;
    alloc_entry.opcode          = in_inst[6:0];
    alloc_entry.predicted_taken = in_predicted_taken;
  end

  // Decode-facing combinational outputs. A same-cycle CDB broadcast wins the
  // value over the stored result so decode never sees a stale operand.
  always_comb begin
    out_rob_tobe_tag = tail;
    out_full         = (count == TAG_W'(ROB_SIZE - 1));

    out_query_tag1_ready   = 1'b0;
    out_query_ready_value1 = '0;
    if (in_query_tag1 != '0) begin
      if (in_cdb_ena && (in_cdb_tag == in_query_tag1)) begin
        out_query_tag1_ready   = 1'b1;
        out_query_ready_value1 = in_cdb_value;
      end else if (entries[in_query_tag1].valid && entries[in_query_tag1].ready) begin
        out_query_tag1_ready   = 1'b1;
        out_query_ready_value1 = entries[in_query_tag1].value;
      end
    end

    out_query_tag2_ready   = 1'b0;
    out_query_ready_value2 = '0;
    if (in_query_tag2 != '0) begin
      if (in_cdb_ena && (in_cdb_tag == in_query_tag2)) begin
        out_query_tag2_ready   = 1'b1;
        out_query_ready_value2 = in_cdb_value;
      end else if (entries[in_query_tag2].valid && entries[in_query_tag2].ready) begin
        out_query_tag2_ready   = 1'b1;
        out_query_ready_value2 = entries[in_query_tag2].value;
      end
    end
  end

  // State register: pointers, entry array and registered commit outputs.
  // Later assignments in this block take precedence, so a flush clears the
  // valid bits written by allocation or CDB in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= TAG_W'(1);
      tail  <= TAG_W'(1);
      count <= '0;
      for (int unsigned i = 0; i < ROB_SIZE; i++) begin
        entries[i] <= '0;
      end
      out_commit_ena       <= 1'b0;
      out_store_commit_ena <= 1'b0;
      out_rollback         <= 1'b0;
      out_commit_reg       <= '0;
      out_commit_value     <= '0;
      out_commit_tag       <= '0;
      out_rollback_pc      <= '0;
    end else begin
      head  <= head_n;
      tail  <= tail_n;
      count <= count_n;

      out_commit_ena       <= 1'b0;
      out_store_commit_ena <= 1'b0;
      out_rollback         <= 1'b0;

      if (cdb_write) begin
        entries[in_cdb_tag].ready  <= 1'b1;
        entries[in_cdb_tag].value  <= in_cdb_value;
        entries[in_cdb_tag].taken  <= in_cdb_taken;
        entries[in_cdb_tag].target <= in_cdb_target;
      end

      if (alloc_go) begin
        entries[tail] <= alloc_entry;
      end

      if (commit_go) begin
        entries[head].valid  <= 1'b0;
        out_commit_reg       <= head_entry.rd;
        out_commit_value     <= head_entry.value;
        out_commit_tag       <= head;
        out_commit_ena       <= commit_writes_reg;
        out_store_commit_ena <= (head_class == OPC_STORE);
      end

      if (mispredict) begin
        for (int unsigned i = 0; i < ROB_SIZE; i++) begin
          entries[i].valid <= 1'b0;
        end
        out_rollback    <= 1'b1;
        out_rollback_pc <= redirect_pc;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;

  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam int         CAP     = 15;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_assign_ena;
  logic [4:0]  in_reg_rd;
  logic [31:0] in_current_pc;
  logic [31:0] in_inst;
  logic        in_predicted_taken;
  logic [3:0]  out_rob_tobe_tag;
  logic        out_full;
  logic [3:0]  in_query_tag1, in_query_tag2;
  logic        out_query_tag1_ready, out_query_tag2_ready;
  logic [31:0] out_query_ready_value1, out_query_ready_value2;
  logic        in_cdb_ena;
  logic [3:0]  in_cdb_tag;
  logic [31:0] in_cdb_value;
  logic        in_cdb_taken;
  logic [31:0] in_cdb_target;
  logic        out_commit_ena;
  logic [4:0]  out_commit_reg;
  logic [31:0] out_commit_value;
  logic [3:0]  out_commit_tag;
  logic        out_store_commit_ena;
  logic        out_rollback;
  logic [31:0] out_rollback_pc;

  reorder_buffer dut (
    .clk(clk), .rst(rst),
    .in_assign_ena(in_assign_ena), .in_reg_rd(in_reg_rd),
    .in_current_pc(in_current_pc), .in_inst(in_inst),
    .in_predicted_taken(in_predicted_taken),
    .out_rob_tobe_tag(out_rob_tobe_tag), .out_full(out_full),
    .in_query_tag1(in_query_tag1), .in_query_tag2(in_query_tag2),
    .out_query_tag1_ready(out_query_tag1_ready),
    .out_query_tag2_ready(out_query_tag2_ready),
    .out_query_ready_value1(out_query_ready_value1),
    .out_query_ready_value2(out_query_ready_value2),
    .in_cdb_ena(in_cdb_ena), .in_cdb_tag(in_cdb_tag),
    .in_cdb_value(in_cdb_value), .in_cdb_taken(in_cdb_taken),
    .in_cdb_target(in_cdb_target),
    .out_commit_ena(out_commit_ena), .out_commit_reg(out_commit_reg),
    .out_commit_value(out_commit_value), .out_commit_tag(out_commit_tag),
    .out_store_commit_ena(out_store_commit_ena),
    .out_rollback(out_rollback), .out_rollback_pc(out_rollback_pc)
  );

  // Reference model: program-ordered queue of in-flight instructions.
  typedef struct {
    int          tag;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [6:0]  op;
    logic        pred;
    logic        rdy;
    logic [31:0] value;
    logic        taken;
    logic [31:0] target;
  } ent_t;

  ent_t        mq[$];
  int          m_next = 1;
  logic        e_ce = 0, e_se = 0, e_rb = 0;
  logic [4:0]  e_reg = 0;
  logic [31:0] e_val = 0, e_rbpc = 0;
  int          e_tag = 0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic void ref_query(input logic [3:0] t, output logic r, output logic [31:0] v);
    r = 1'b0;
    v = '0;
    if (t == 4'd0) return;
    if (in_cdb_ena && in_cdb_tag == t) begin
      r = 1'b1;
      v = in_cdb_value;
      return;
    end
    foreach (mq[i]) begin
      if (mq[i].tag == int'(t) && mq[i].rdy) begin
        r = 1'b1;
        v = mq[i].value;
      end
    end
  endfunction

  task automatic model_edge();
    ent_t        h;
    ent_t        n;
    bit          commit, flush, was_full;
    logic [31:0] rbpc;
    e_ce = 0; e_se = 0; e_rb = 0;
    if (rst) begin
      mq.delete();
      m_next = 1;
      e_reg = 0; e_val = 0; e_tag = 0; e_rbpc = 0;
      return;
    end
    was_full = (mq.size() == CAP);
    commit   = (mq.size() > 0) && mq[0].rdy;
    flush    = 0;
    rbpc     = 0;
    if (commit) begin
      h     = mq[0];
      e_reg = h.rd;
      e_val = h.value;
      e_tag = h.tag;
      e_se  = (h.op == OP_SW);
      e_ce  = (h.rd != 0) && (h.op != OP_BR) && (h.op != OP_SW);
      if (h.op == OP_BR && h.taken != h.pred) begin
        flush = 1;
        rbpc  = h.taken ? h.target : h.pc + 32'd4;
      end
      if (h.op == OP_JALR) begin
        flush = 1;
        rbpc  = h.target;
      end
    end
    if (in_cdb_ena && in_cdb_tag != 0) begin
      foreach (mq[i]) begin
        if (mq[i].tag == int'(in_cdb_tag)) begin
          mq[i].rdy    = 1'b1;
          mq[i].value  = in_cdb_value;
          mq[i].taken  = in_cdb_taken;
          mq[i].target = in_cdb_target;
        end
      end
    end
    if (commit) void'(mq.pop_front());
    if (flush) begin
      mq.delete();
      m_next = 1;
      e_rb   = 1;
      e_rbpc = rbpc;
    end else if (in_assign_ena && !was_full) begin
      n = '{tag: m_next, rd: in_reg_rd, pc: in_current_pc, op: in_inst[6:0],
            pred: in_predicted_taken, rdy: 1'b0, value: '0, taken: 1'b0, target: '0};
      mq.push_back(n);
      m_next = (m_next == CAP) ? 1 : m_next + 1;
    end
  endtask

  // One clock: check decode-facing outputs, clock, then check registered outputs.
  task automatic step();
    logic        r;
    logic [31:0] v;
    #1;
    chk("tobe_tag", 32'(out_rob_tobe_tag), 32'(m_next));
    chk("full", 32'(out_full), 32'(mq.size() == CAP));
    ref_query(in_query_tag1, r, v);
    chk("q1_ready", 32'(out_query_tag1_ready), 32'(r));
    chk("q1_value", out_query_ready_value1, v);
    ref_query(in_query_tag2, r, v);
    chk("q2_ready", 32'(out_query_tag2_ready), 32'(r));
    chk("q2_value", out_query_ready_value2, v);
    @(posedge clk);
    model_edge();
    #1;
    chk("commit_ena", 32'(out_commit_ena), 32'(e_ce));
    chk("store_ena", 32'(out_store_commit_ena), 32'(e_se));
    chk("rollback", 32'(out_rollback), 32'(e_rb));
    chk("commit_reg", 32'(out_commit_reg), 32'(e_reg));
    chk("commit_value", out_commit_value, e_val);
    chk("commit_tag", 32'(out_commit_tag), 32'(e_tag));
    chk("rollback_pc", out_rollback_pc, e_rbpc);
  endtask

  task automatic idle();
    in_assign_ena = 0; in_reg_rd = 0; in_current_pc = 0; in_inst = 0;
    in_predicted_taken = 0; in_query_tag1 = 0; in_query_tag2 = 0;
    in_cdb_ena = 0; in_cdb_tag = 0; in_cdb_value = 0; in_cdb_taken = 0;
    in_cdb_target = 0;
  endtask

  task automatic asg(input logic [6:0] op, input logic [4:0] rd,
                     input logic [31:0] pc, input logic pred);
    logic [31:0] r;
    r = $urandom;
    in_assign_ena      = 1;
    in_reg_rd          = rd;
    in_current_pc      = pc;
    in_inst            = {r[31:7], op};
    in_predicted_taken = pred;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [31:0] val,
                     input logic tk, input logic [31:0] tgt);
    in_cdb_ena    = 1;
    in_cdb_tag    = tag;
    in_cdb_value  = val;
    in_cdb_taken  = tk;
    in_cdb_target = tgt;
  endtask

  initial begin
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    step();
    rst = 0;

    // Single ADDI through allocate, writeback and commit.
    step();
    asg(OP_ADDI, 5, 32'h0, 0); step();
    idle();
    chk("t1_next_tag", 32'(out_rob_tobe_tag), 32'd2);
    cdb(1, 32'h2A, 0, 0); step();
    idle(); step();
    chk("t1_commit_ena", 32'(out_commit_ena), 32'd1);
    chk("t1_commit_reg", 32'(out_commit_reg), 32'd5);
    chk("t1_commit_value", out_commit_value, 32'h2A);
    chk("t1_commit_tag", 32'(out_commit_tag), 32'd1);

    // Fill to capacity, wrapped tail, ignored assign while full.
    rst = 1; idle(); step(); rst = 0;
    for (int i = 0; i < CAP; i++) begin
      asg(OP_ADDI, 5'(i + 1), 32'(i * 4), 0); step();
    end
    idle();
    chk("t2_full", 32'(out_full), 32'd1);
    chk("t2_tail_wrap", 32'(out_rob_tobe_tag), 32'd1);
    asg(OP_ADDI, 9, 32'h999, 0); step();
    idle();
    chk("t2_still_full", 32'(out_full), 32'd1);
    cdb(1, 32'h11, 0, 0); step();
    idle(); step();
    chk("t2_commit_tag", 32'(out_commit_tag), 32'd1);
    chk("t2_not_full", 32'(out_full), 32'd0);
    chk("t2_next_tag", 32'(out_rob_tobe_tag), 32'd1);

    // Query bypass from the CDB, and the reserved tag 0.
    in_query_tag1 = 3; in_query_tag2 = 0;
    cdb(3, 32'h77, 0, 0);
    #1;
    chk("t3_q3_ready", 32'(out_query_tag1_ready), 32'd1);
    chk("t3_q3_value", out_query_ready_value1, 32'h77);
    chk("t3_q0_ready", 32'(out_query_tag2_ready), 32'd0);
    chk("t3_q0_value", out_query_ready_value2, 32'd0);
    step();
    for (int t = 2; t <= CAP; t++) begin
      idle();
      in_query_tag1 = 4'(t); in_query_tag2 = 3;
      cdb(4'(t), 32'h1000 + 32'(t), 0, 0); step();
    end
    idle();
    repeat (16) step();

    // Taken branch predicted not-taken; younger ready entry must not commit.
    rst = 1; idle(); step(); rst = 0;
    asg(OP_BR, 0, 32'h100, 0); step();
    asg(OP_ADDI, 3, 32'h104, 0); step();
    idle(); cdb(2, 32'h55, 0, 0); step();
    idle(); cdb(1, 32'h0, 1, 32'h180); step();
    idle(); asg(OP_ADDI, 4, 32'h108, 0); step();
    idle();
    chk("t4_rollback", 32'(out_rollback), 32'd1);
    chk("t4_rollback_pc", out_rollback_pc, 32'h180);
    chk("t4_next_tag", 32'(out_rob_tobe_tag), 32'd1);
    chk("t4_not_full", 32'(out_full), 32'd0);
    repeat (3) step();

    // Not-taken branch predicted taken, then JAL and JALR.
    asg(OP_BR, 0, 32'h200, 1); step();
    idle(); cdb(1, 32'h0, 0, 32'h999); step();
    idle(); step();
    chk("t5_br_rollback_pc", out_rollback_pc, 32'h204);
    asg(OP_JAL, 1, 32'h300, 1); step();
    idle(); cdb(1, 32'h304, 1, 32'h400); step();
    idle(); step();
    chk("t5_jal_commit", 32'(out_commit_ena), 32'd1);
    chk("t5_jal_value", out_commit_value, 32'h304);
    chk("t5_jal_no_rollback", 32'(out_rollback), 32'd0);
    asg(OP_JALR, 2, 32'h500, 0); step();
    idle(); cdb(2, 32'h504, 1, 32'h3000); step();
    idle(); step();
    chk("t5_jalr_rollback", 32'(out_rollback), 32'd1);
    chk("t5_jalr_pc", out_rollback_pc, 32'h3000);
    chk("t5_jalr_commit", 32'(out_commit_ena), 32'd1);
    chk("t5_jalr_reg", 32'(out_commit_reg), 32'd2);

    // Store release without regfile write.
    asg(OP_SW, 7, 32'h600, 0); step();
    idle(); cdb(1, 32'h0, 0, 0); step();
    idle(); step();
    chk("t6_store_ena", 32'(out_store_commit_ena), 32'd1);
    chk("t6_no_reg_write", 32'(out_commit_ena), 32'd0);
    chk("t6_store_tag", 32'(out_commit_tag), 32'd1);

    // Reset with pending (one ready) entries discards them.
    for (int i = 0; i < 5; i++) begin
      asg(OP_ADDI, 5'(10 + i), 32'h700 + 32'(4 * i), 0); step();
    end
    idle(); cdb(2, 32'hAB, 0, 0); step();
    idle(); rst = 1; step(); rst = 0;
    chk("t7_no_commit", 32'(out_commit_ena), 32'd0);
    chk("t7_tag_reset", 32'(out_rob_tobe_tag), 32'd1);
    repeat (3) step();

    // Randomised traffic against the queue model.
    for (int c = 0; c < 3000; c++) begin
      int unsigned sel;
      idle();
      rst = ($urandom % 256) == 0;
      if ($urandom % 10 < 6) begin
        sel = $urandom % 10;
        case (sel)
          5: asg(OP_BR,   5'($urandom), {$urandom} & 32'hFFFF_FFFC, 1'($urandom));
          6: asg(OP_SW,   5'($urandom), {$urandom} & 32'hFFFF_FFFC, 0);
          7: asg(OP_JAL,  5'($urandom), {$urandom} & 32'hFFFF_FFFC, 1);
          8: asg(OP_JALR, 5'($urandom), {$urandom} & 32'hFFFF_FFFC, 0);
          default: asg(OP_ADDI, 5'($urandom), {$urandom} & 32'hFFFF_FFFC, 0);
        endcase
      end
      if ($urandom % 10 < 7) begin
        if (mq.size() > 0 && ($urandom % 4) != 0)
          cdb(4'(mq[$urandom_range(0, mq.size() - 1)].tag), $urandom, 1'($urandom), $urandom);
        else
          cdb(4'($urandom), $urandom, 1'($urandom), $urandom);
      end
      if (mq.size() > 0 && ($urandom % 2) != 0)
        in_query_tag1 = 4'(mq[$urandom_range(0, mq.size() - 1)].tag);
      else
        in_query_tag1 = 4'($urandom);
      in_query_tag2 = ($urandom % 3 == 0) ? in_cdb_tag : 4'($urandom);
      step();
    end
    rst = 0;
    idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
